// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_unit
// Purpose  : Memory-stage load path. Issues word reads to a 1-cycle-latency
//            synchronous memory, splits word-crossing loads into two reads and
//            returns the sign/zero-extended byte, half or word.
// Revision : 1.0 - initial release
// ============================================================================
module load_unit #(
    parameter int SUPPORT_MISALIGNED = 1,
    parameter int ADDR_WIDTH         = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] Addr,
    output logic                  MemRead,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic [31:0]           MemReadData,
    output logic                  RespValid,
    output logic [31:0]           RespData,
    output logic                  Error,
    output logic                  Busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2
    } stateType;

    stateType               r_state;
    logic [2:0]             r_funct3;
    logic [1:0]             r_offset;
    logic [ADDR_WIDTH-3:0]  r_wordAddr;
    logic                   r_misaligned;
    logic [31:0]            r_lo;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misReq;
    logic        w_errReq;
    logic [31:0] w_lo;
    logic [23:0] w_hi;
    logic [31:0] w_aligned;
    logic [31:0] w_result;

    function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [31:0] t);
        case (f3)
            3'b000:  extendLoad = {{24{t[7]}}, t[7:0]};
            3'b001:  extendLoad = {{16{t[15]}}, t[15:0]};
            3'b100:  extendLoad = {24'd0, t[7:0]};
            3'b101:  extendLoad = {16'd0, t[15:0]};
            default: extendLoad = t;
        endcase
    endfunction

    assign ReqReady  = (r_state == IDLE);
    assign Busy      = (r_state != IDLE);
    assign w_accept  = ReqValid && ReqReady;
    assign w_illegal = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11);
    assign w_misReq  = ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00)) ||
                       ((Funct3[1:0] == 2'b01) && (Addr[1:0] == 2'b11));
    assign w_errReq  = w_illegal || (w_misReq && (SUPPORT_MISALIGNED == 0));

    // In WAIT_HI the low word comes from r_lo and the upper one from memory;
    // only hi[23:0] can ever reach the low 32 bits of the shifted pair.
    assign w_lo = (r_state == WAIT_HI) ? r_lo : MemReadData;
    assign w_hi = (r_state == WAIT_HI) ? MemReadData[23:0] : 24'd0;

    always_comb begin
        w_aligned = w_lo;
        case (r_offset)
            2'd1:    w_aligned = {w_hi[7:0],  w_lo[31:8]};
            2'd2:    w_aligned = {w_hi[15:0], w_lo[31:16]};
            2'd3:    w_aligned = {w_hi[23:0], w_lo[31:24]};
            default: w_aligned = w_lo;
        endcase
    end

    assign w_result = extendLoad(r_funct3, w_aligned);

    always_comb begin
        MemRead = 1'b0;
        MemAddr = '0;
        if ((r_state == IDLE) && w_accept && !w_errReq) begin
            MemRead = 1'b1;
            MemAddr = {Addr[ADDR_WIDTH-1:2], 2'b00};
        end else if ((r_state == WAIT_LO) && r_misaligned) begin
            MemRead = 1'b1;
            MemAddr = {r_wordAddr + (ADDR_WIDTH-2)'(1), 2'b00};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_funct3     <= 3'd0;
            r_offset     <= 2'd0;
            r_wordAddr   <= '0;
            r_misaligned <= 1'b0;
            r_lo         <= 32'd0;
            RespValid    <= 1'b0;
            RespData     <= 32'd0;
            Error        <= 1'b0;
        end else begin
            RespValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= Funct3;
                        r_offset   <= Addr[1:0];
                        r_wordAddr <= Addr[ADDR_WIDTH-1:2];
                        if (w_errReq) begin
                            RespValid <= 1'b1;
                            RespData  <= 32'd0;
                            Error     <= 1'b1;
                        end else begin
                            r_misaligned <= w_misReq;
                            r_state      <= WAIT_LO;
                        end
                    end
                end
                WAIT_LO: begin
                    if (r_misaligned) begin
                        r_lo    <= MemReadData;
                        r_state <= WAIT_HI;
                    end else begin
                        RespValid <= 1'b1;
                        RespData  <= w_result;
                        Error     <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                WAIT_HI: begin
                    RespValid <= 1'b1;
                    RespData  <= w_result;
                    Error     <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_unit
// Purpose  : Directed self-checking bench for load_unit (misaligned split and
//            error-flagging variants side by side).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_unit;

    logic        CLK;
    logic        RESET;
    logic        ReqValid, ReqReady, MemRead, RespValid, Error, Busy;
    logic [2:0]  Funct3;
    logic [31:0] Addr, MemAddr, MemReadData, RespData;

    logic        ReqValid2, ReqReady2, MemRead2, RespValid2, Error2, Busy2;
    logic [2:0]  Funct3_2;
    logic [31:0] Addr2, MemAddr2, MemReadData2, RespData2;

    int nVec = 0;
    int nErr = 0;

    load_unit #(.SUPPORT_MISALIGNED(1), .ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Funct3(Funct3), .Addr(Addr), .MemRead(MemRead), .MemAddr(MemAddr),
        .MemReadData(MemReadData), .RespValid(RespValid), .RespData(RespData),
        .Error(Error), .Busy(Busy)
    );

    load_unit #(.SUPPORT_MISALIGNED(0), .ADDR_WIDTH(32)) dutNoMis (
        .CLK(CLK), .RESET(RESET), .ReqValid(ReqValid2), .ReqReady(ReqReady2),
        .Funct3(Funct3_2), .Addr(Addr2), .MemRead(MemRead2), .MemAddr(MemAddr2),
        .MemReadData(MemReadData2), .RespValid(RespValid2), .RespData(RespData2),
        .Error(Error2), .Busy(Busy2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0100: memWord = 32'h8765_4321;
            32'h0000_0104: memWord = 32'hFFEE_DDCC;
            32'hFFFF_FFFC: memWord = 32'h1122_3344;
            32'h0000_0000: memWord = 32'h5566_7788;
            default:       memWord = 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (MemRead)  MemReadData  <= memWord(MemAddr);
        if (MemRead2) MemReadData2 <= memWord(MemAddr2);
    end

    // Apply a request (or idle) just after the falling edge, then let it settle.
    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a);
        @(negedge CLK);
        ReqValid = v; Funct3 = f3; Addr = a;
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        nVec++; if (RespValid !== 1'b0) begin nErr++; $display("FAIL reset_respvalid: got %b want 0", RespValid); end
        nVec++; if (RespData !== 32'd0) begin nErr++; $display("FAIL reset_respdata: got %h want 00000000", RespData); end
        nVec++; if (Error !== 1'b0) begin nErr++; $display("FAIL reset_error: got %b want 0", Error); end
        nVec++; if (Busy !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b want 0", Busy); end
        nVec++; if (ReqReady !== 1'b1) begin nErr++; $display("FAIL reset_reqready: got %b want 1", ReqReady); end
        nVec++; if (MemRead !== 1'b0) begin nErr++; $display("FAIL reset_memread: got %b want 0", MemRead); end
    endtask

    task automatic test_lb;
        drive(1'b1, 3'b000, 32'h103);
        nVec++; if (MemRead !== 1'b1) begin nErr++; $display("FAIL lb_memread_T: got %b want 1", MemRead); end
        nVec++; if (MemAddr !== 32'h100) begin nErr++; $display("FAIL lb_memaddr_T: got %h want 00000100", MemAddr); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (MemRead !== 1'b0) begin nErr++; $display("FAIL lb_memread_T1: got %b want 0", MemRead); end
        nVec++; if (Busy !== 1'b1) begin nErr++; $display("FAIL lb_busy_T1: got %b want 1", Busy); end
        nVec++; if (RespValid !== 1'b0) begin nErr++; $display("FAIL lb_early_resp: got %b want 0", RespValid); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1) begin nErr++; $display("FAIL lb_respvalid_T2: got %b want 1", RespValid); end
        nVec++; if (RespData !== 32'hFFFF_FF87) begin nErr++; $display("FAIL lb_data: got %h want ffffff87", RespData); end
        nVec++; if (Error !== 1'b0) begin nErr++; $display("FAIL lb_error: got %b want 0", Error); end
        nVec++; if (Busy !== 1'b0) begin nErr++; $display("FAIL lb_busy_T2: got %b want 0", Busy); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b0) begin nErr++; $display("FAIL lb_pulse_width: got %b want 0", RespValid); end
    endtask

    task automatic test_zero_extend;
        drive(1'b1, 3'b101, 32'h102);
        drive(1'b0, 3'b000, 32'h0);
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1 || RespData !== 32'h0000_8765) begin nErr++; $display("FAIL lhu_data: got v=%b %h want v=1 00008765", RespValid, RespData); end
        drive(1'b1, 3'b100, 32'h100);
        drive(1'b0, 3'b000, 32'h0);
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1 || RespData !== 32'h0000_0021) begin nErr++; $display("FAIL lbu_data: got v=%b %h want v=1 00000021", RespValid, RespData); end
    endtask

    task automatic test_misaligned_lw;
        drive(1'b1, 3'b010, 32'h101);
        nVec++; if (MemRead !== 1'b1 || MemAddr !== 32'h100) begin nErr++; $display("FAIL mlw_first_read: got rd=%b %h want rd=1 00000100", MemRead, MemAddr); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (MemRead !== 1'b1 || MemAddr !== 32'h104) begin nErr++; $display("FAIL mlw_second_read: got rd=%b %h want rd=1 00000104", MemRead, MemAddr); end
        nVec++; if (Busy !== 1'b1 || ReqReady !== 1'b0) begin nErr++; $display("FAIL mlw_busy_T1: got busy=%b ready=%b want 1 0", Busy, ReqReady); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (Busy !== 1'b1 || MemRead !== 1'b0 || RespValid !== 1'b0) begin nErr++; $display("FAIL mlw_T2: got busy=%b rd=%b rv=%b want 1 0 0", Busy, MemRead, RespValid); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1 || RespData !== 32'hCC87_6543) begin nErr++; $display("FAIL mlw_data: got v=%b %h want v=1 cc876543", RespValid, RespData); end
        nVec++; if (Busy !== 1'b0) begin nErr++; $display("FAIL mlw_busy_T3: got %b want 0", Busy); end
    endtask

    task automatic test_misaligned_lh;
        drive(1'b1, 3'b001, 32'h103);
        nVec++; if (MemAddr !== 32'h100) begin nErr++; $display("FAIL mlh_first_addr: got %h want 00000100", MemAddr); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (MemRead !== 1'b1 || MemAddr !== 32'h104) begin nErr++; $display("FAIL mlh_second_read: got rd=%b %h want rd=1 00000104", MemRead, MemAddr); end
        drive(1'b0, 3'b000, 32'h0);
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1 || RespData !== 32'hFFFF_CC87) begin nErr++; $display("FAIL mlh_data: got v=%b %h want v=1 ffffcc87", RespValid, RespData); end

        @(negedge CLK);
        ReqValid2 = 1'b1; Funct3_2 = 3'b001; Addr2 = 32'h103;
        #1;
        nVec++; if (MemRead2 !== 1'b0) begin nErr++; $display("FAIL nomis_memread: got %b want 0", MemRead2); end
        @(negedge CLK);
        ReqValid2 = 1'b0;
        #1;
        nVec++; if (RespValid2 !== 1'b1 || Error2 !== 1'b1 || RespData2 !== 32'd0) begin nErr++; $display("FAIL nomis_resp: got v=%b e=%b %h want 1 1 00000000", RespValid2, Error2, RespData2); end
        nVec++; if (Busy2 !== 1'b0 || MemRead2 !== 1'b0) begin nErr++; $display("FAIL nomis_idle: got busy=%b rd=%b want 0 0", Busy2, MemRead2); end
    endtask

    task automatic test_illegal;
        drive(1'b1, 3'b011, 32'h100);
        nVec++; if (MemRead !== 1'b0) begin nErr++; $display("FAIL ill_memread_T: got %b want 0", MemRead); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1 || Error !== 1'b1 || RespData !== 32'd0) begin nErr++; $display("FAIL ill_resp: got v=%b e=%b %h want 1 1 00000000", RespValid, Error, RespData); end
        nVec++; if (MemRead !== 1'b0 || Busy !== 1'b0) begin nErr++; $display("FAIL ill_idle: got rd=%b busy=%b want 0 0", MemRead, Busy); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b0 || Error !== 1'b1) begin nErr++; $display("FAIL ill_hold: got v=%b e=%b want 0 1", RespValid, Error); end
    endtask

    task automatic test_wrap;
        drive(1'b1, 3'b010, 32'hFFFF_FFFE);
        nVec++; if (MemAddr !== 32'hFFFF_FFFC) begin nErr++; $display("FAIL wrap_first_addr: got %h want fffffffc", MemAddr); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (MemRead !== 1'b1 || MemAddr !== 32'h0) begin nErr++; $display("FAIL wrap_second_addr: got rd=%b %h want rd=1 00000000", MemRead, MemAddr); end
        drive(1'b0, 3'b000, 32'h0);
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1 || RespData !== 32'h7788_1122 || Error !== 1'b0) begin nErr++; $display("FAIL wrap_data: got v=%b e=%b %h want 1 0 77881122", RespValid, Error, RespData); end
    endtask

    task automatic test_reset_mid;
        int seen;
        drive(1'b1, 3'b010, 32'h101);
        drive(1'b0, 3'b000, 32'h0);
        @(negedge CLK);
        nVec++; if (Busy !== 1'b1) begin nErr++; $display("FAIL rst_mid_inflight: got busy=%b want 1", Busy); end
        RESET = 1'b1;
        #1;
        nVec++; if (Busy !== 1'b0 || MemRead !== 1'b0 || MemAddr !== 32'd0 || RespValid !== 1'b0 || RespData !== 32'd0 || Error !== 1'b0) begin
            nErr++; $display("FAIL rst_mid_outputs: got busy=%b rd=%b addr=%h rv=%b data=%h e=%b want all 0", Busy, MemRead, MemAddr, RespValid, RespData, Error);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        nVec++; if (ReqReady !== 1'b1) begin nErr++; $display("FAIL rst_mid_ready: got %b want 1", ReqReady); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'b000, 32'h0);
            if (RespValid !== 1'b0) seen++;
        end
        nVec++; if (seen != 0) begin nErr++; $display("FAIL rst_mid_no_resp: got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 3'b010, 32'h100);
        drive(1'b0, 3'b000, 32'h0);
        drive(1'b1, 3'b010, 32'h104);
        nVec++; if (RespValid !== 1'b1 || RespData !== 32'h8765_4321) begin nErr++; $display("FAIL b2b_first: got v=%b %h want v=1 87654321", RespValid, RespData); end
        nVec++; if (ReqReady !== 1'b1 || MemRead !== 1'b1 || MemAddr !== 32'h104) begin nErr++; $display("FAIL b2b_accept: got rdy=%b rd=%b %h want 1 1 00000104", ReqReady, MemRead, MemAddr); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b0 || Busy !== 1'b1) begin nErr++; $display("FAIL b2b_gap: got v=%b busy=%b want 0 1", RespValid, Busy); end
        drive(1'b0, 3'b000, 32'h0);
        nVec++; if (RespValid !== 1'b1 || RespData !== 32'hFFEE_DDCC || Error !== 1'b0) begin nErr++; $display("FAIL b2b_second: got v=%b e=%b %h want 1 0 ffeeddcc", RespValid, Error, RespData); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ReqValid = 1'b0; Funct3 = 3'd0; Addr = 32'd0;
        ReqValid2 = 1'b0; Funct3_2 = 3'd0; Addr2 = 32'd0;
        MemReadData = 32'd0; MemReadData2 = 32'd0;
        test_reset();
        test_lb();
        test_zero_extend();
        test_misaligned_lw();
        test_misaligned_lh();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side counterpart of the store alignment path in the memory stage.
- Accepts a load request: funct3 plus byte address.
- Reads from a synchronous data memory with 1-cycle read latency and extracts the byte, half or word.
- Sign- or zero-extends the result; misaligned loads are split into two word reads under a small FSM, with Busy stalling the pipeline.

Parameters:
- SUPPORT_MISALIGNED, 1, 1 = split word-crossing loads into two reads; 0 = flag them as Error with no memory access.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- CLK  input  1  core clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ReqValid  input  1  load request present.
- ReqReady  output  1  block can accept a request this cycle.
- Funct3  input  3  RISC-V load funct3.
- Addr  input  ADDR_WIDTH  byte address of the load.
- MemRead  output  1  memory read strobe.
- MemAddr  output  ADDR_WIDTH  word-aligned read address, bits [1:0] always 0.
- MemReadData  input  32  read data, valid the cycle after MemRead.
- RespValid  output  1  one-cycle pulse; RespData/Error valid.
- RespData  output  32  extended load result.
- Error  output  1  qualifies RespValid: illegal funct3, or misaligned with SUPPORT_MISALIGNED=0.
- Busy  output  1  FSM not in IDLE (pipeline stall).

Behaviour:
- Reset is asynchronous and active-high; one clock (CLK).
- Reset values: state=IDLE, RespValid=0, RespData=0, Error=0, Busy=0. ReqReady=1 after release.
- Reset mid-operation: in-flight access is abandoned and no RespValid is produced.
- States: IDLE, WAIT_LO, WAIT_HI.
- ReqReady=(state==IDLE). A request is accepted when ReqValid&&ReqReady.
- MemRead/MemAddr are combinational:
  - IDLE with accepted legal request (no Error path): MemRead=1, MemAddr={Addr[ADDR_WIDTH-1:2],2'b00}.
  - WAIT_LO with misaligned flag set: MemRead=1, MemAddr=latched word address +4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0x00000000).
  - Otherwise MemRead=0 and MemAddr=0.
- Accept actions: latch Funct3, Addr[1:0] and word address.
- Legal funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Illegal funct3 (011, 110, 111):
  - No memory access; state stays IDLE.
  - Next cycle RespValid=1, Error=1, RespData=0.
- Misaligned: LW with offset≠0, or LH/LHU with offset==3.
  - SUPPORT_MISALIGNED=0: handled like illegal funct3 (no access, Error=1 response at T+1).
  - Otherwise go to WAIT_LO.
- Aligned legal requests also go to WAIT_LO.
- WAIT_LO:
  - Capture MemReadData into lo.
  - If misaligned, go to WAIT_HI; else go to IDLE and register the response.
- WAIT_HI: capture MemReadData into hi, go to IDLE and register the response.
- Response computation:
  - t = ({hi,lo} >> (offset*8))[31:0]; hi=0 for aligned accesses.
  - LB: sext(t[7:0]). LBU: zext(t[7:0]).
  - LH: sext(t[15:0]). LHU: zext(t[15:0]).
  - LW: t.
- RespValid is registered and high exactly one cycle, on the cycle the state returns to IDLE.
- Latency from accept at cycle T: aligned RespValid at T+2; misaligned at T+3; error at T+1.
- Back-to-back: a new request may be accepted in the same cycle RespValid is high.
- RespData and Error hold their values until the next response. Error=0 on normal responses.
- ReqValid while Busy is ignored; the requester must hold it.
- No response backpressure.

Test Plan:
- Memory contents for all tests: 0x100=0x87654321, 0x104=0xFFEEDDCC.
- LB at 0x103, accepted T -> MemRead at T only with MemAddr=0x100; RespValid at T+2, RespData=0xFFFFFF87, Error=0.
- LHU at 0x102 -> RespData=0x00008765 at T+2; LBU at 0x100 -> 0x00000021.
- LW at 0x101 (misaligned) -> MemAddr 0x100 at T, 0x104 at T+1; Busy high T+1..T+2; RespValid at T+3, RespData=0xCC876543.
- LH at 0x103 -> two reads, RespData=0xFFFFCC87 at T+3. Repeat with SUPPORT_MISALIGNED=0 -> no MemRead, RespValid at T+1, Error=1, RespData=0.
- Funct3=011 at 0x100 -> MemRead never asserted, RespValid+Error at T+1. LW at 0xFFFFFFFE -> second MemAddr=0x00000000.
- Assert RESET during WAIT_HI of a misaligned LW -> all outputs 0 immediately; after release ReqReady=1 and RespValid never pulses for the aborted load. Then back-to-back aligned LW 0x100 and 0x104 -> responses 0x87654321 and 0xFFEEDDCC, second accepted on the first RespValid cycle.
